// File: rtl/tile_cfg_pkg.sv
// Shared types for tile configuration-chain controllers: FSM states,
// scan-register commands and the bypass/commit request encodings.
package tile_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    COMMIT   = 2'd2,
    READBACK = 2'd3
  } cfg_state_e;

  typedef enum logic [1:0] {
    SCAN_HOLD  = 2'd0,
    SCAN_SHIFT = 2'd1,
    SCAN_LOAD  = 2'd2,
    SCAN_CLR   = 2'd3
  } scan_cmd_e;

  localparam logic BYPASS_ON  = 1'b1;
  localparam logic COMMIT_REQ = 1'b1;

endpackage

// File: rtl/ccff_scan_reg.sv
// Serial configuration scan register with parallel load and a shift counter
// that saturates once every configuration bit has been filled.
module ccff_scan_reg
  import tile_cfg_pkg::*;
#(
  parameter int CFG_BITS = 64,
  parameter int CNT_W    = $clog2(CFG_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  scan_cmd_e           cmd,
  input  logic                ser_in,
  input  logic [CFG_BITS-1:0] load_data,
  output logic [CFG_BITS-1:0] sr,
  output logic                full
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

  logic [CFG_BITS-1:0] sr_r;
  logic [CNT_W-1:0]    cnt_r;

  // Scan data and fill counter; a parallel load restarts the fill count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_r  <= {CFG_BITS{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (cmd)
        SCAN_SHIFT: begin
          sr_r <= {sr_r[CFG_BITS-2:0], ser_in};
          if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        SCAN_LOAD: begin
          sr_r  <= load_data;
          cnt_r <= {CNT_W{1'b0}};
        end
        SCAN_CLR: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          sr_r  <= sr_r;
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign sr   = sr_r;
  assign full = (cnt_r == CNT_MAX);

endmodule

// File: rtl/tile_ccff_ctrl.sv
// Per-block configuration-chain controller: scan chain segment with bypass,
// atomic commit into a shadow register, readback and under-shift detection.
module tile_ccff_ctrl
  import tile_cfg_pkg::*;
#(
  parameter int   CFG_BITS = 64,
  parameter int   CNT_W    = $clog2(CFG_BITS + 1),
  parameter logic ISO_VAL  = 1'b0
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                ccff_bypass,
  input  logic                cfg_commit,
  input  logic                cfg_readback,
  input  logic                isol_n,
  output logic                ccff_tail,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic                cfg_valid,
  output logic                cfg_err,
  output logic                cfg_done,
  output logic                busy
);

  cfg_state_e          state_r;
  cfg_state_e          state_s;
  scan_cmd_e           scan_cmd_s;
  logic                byp_load_s;
  logic                full_s;
  logic [CFG_BITS-1:0] sr_s;
  logic [CFG_BITS-1:0] shadow_r;
  logic                byp_r;
  logic                valid_r;
  logic                err_r;
  logic                done_r;
  logic                busy_r;

  ccff_scan_reg #(
    .CFG_BITS (CFG_BITS),
    .CNT_W    (CNT_W)
  ) u_scan (
    .clk       (prog_clk),
    .rst_n     (prog_reset_n),
    .cmd       (scan_cmd_s),
    .ser_in    (ccff_head),
    .load_data (shadow_r),
    .sr        (sr_s),
    .full      (full_s)
  );

  // Next state and scan command; the shift of a request cycle happens before
  // the FSM moves to COMMIT/READBACK, and commit outranks readback.
  always_comb begin
    state_s    = state_r;
    scan_cmd_s = SCAN_HOLD;
    byp_load_s = 1'b0;
    case (state_r)
      IDLE, SHIFT: begin
        if (ccff_en) begin
          if (ccff_bypass == BYPASS_ON) begin
            byp_load_s = 1'b1;
          end else begin
            scan_cmd_s = SCAN_SHIFT;
          end
        end else begin
          scan_cmd_s = SCAN_HOLD;
        end
        if (cfg_commit == COMMIT_REQ) begin
          state_s = COMMIT;
        end else if (cfg_readback) begin
          state_s = READBACK;
        end else if (ccff_en) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      COMMIT: begin
        state_s = IDLE;
        if (full_s) begin
          scan_cmd_s = SCAN_CLR;
        end else begin
          scan_cmd_s = SCAN_HOLD;
        end
      end
      READBACK: begin
        state_s    = IDLE;
        scan_cmd_s = SCAN_LOAD;
      end
      default: begin
        state_s    = IDLE;
        scan_cmd_s = SCAN_HOLD;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shadow, bypass flop and status flags; an error stays set until reset.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      shadow_r <= {CFG_BITS{1'b0}};
      byp_r    <= 1'b0;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == COMMIT) || (state_r == READBACK);
      if (byp_load_s) begin
        byp_r <= ccff_head;
      end
      if (state_r == COMMIT) begin
        if (full_s) begin
          shadow_r <= sr_s;
          valid_r  <= 1'b1;
        end else begin
          err_r <= 1'b1;
        end
      end
    end
  end

  assign ccff_tail = (ccff_bypass == BYPASS_ON) ? byp_r : sr_s[CFG_BITS-1];
  assign cfg_out   = isol_n ? shadow_r : {CFG_BITS{ISO_VAL}};
  assign cfg_valid = valid_r;
  assign cfg_err   = err_r;
  assign cfg_done  = done_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_tile_ccff_ctrl.sv
// Self-checking bench for tile_ccff_ctrl: directed vector table, hand-written
// corner sequences and randomized operations against a transaction-level model.
module tb_tile_ccff_ctrl;

  localparam int NB = 64;

  logic          prog_clk = 1'b0;
  logic          prog_reset_n;
  logic          ccff_head;
  logic          ccff_en;
  logic          ccff_bypass;
  logic          cfg_commit;
  logic          cfg_readback;
  logic          isol_n;
  logic          ccff_tail;
  logic [NB-1:0] cfg_out;
  logic          cfg_valid;
  logic          cfg_err;
  logic          cfg_done;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [NB-1:0] m_sr;
  logic [NB-1:0] m_sh;
  int            m_cnt;
  logic          m_bq;
  logic          m_valid;
  logic          m_err;

  typedef struct {
    int          hi;
    int          n;
    logic [63:0] data;
    logic [63:0] exp_out;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  vec_t vt[3];

  tile_ccff_ctrl #(
    .CFG_BITS (NB),
    .ISO_VAL  (1'b1)
  ) dut (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .ccff_head    (ccff_head),
    .ccff_en      (ccff_en),
    .ccff_bypass  (ccff_bypass),
    .cfg_commit   (cfg_commit),
    .cfg_readback (cfg_readback),
    .isol_n       (isol_n),
    .ccff_tail    (ccff_tail),
    .cfg_out      (cfg_out),
    .cfg_valid    (cfg_valid),
    .cfg_err      (cfg_err),
    .cfg_done     (cfg_done),
    .busy         (busy)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  function automatic logic [NB-1:0] exp_out();
    return isol_n ? m_sh : {NB{1'b1}};
  endfunction

  task automatic model_reset();
    m_sr = '0; m_sh = '0; m_cnt = 0; m_bq = 1'b0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  // One enabled shift seen by this tile: bypass bits pass through the single
  // flop, otherwise the bit enters the scan register and the fill count grows.
  task automatic model_shift(input logic b);
    if (ccff_bypass) begin
      m_bq = b;
    end else begin
      m_sr = (m_sr << 1) | NB'(b);
      if (m_cnt < NB) m_cnt++;
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_tail"}, ccff_tail, ccff_bypass ? m_bq : m_sr[NB-1]);
    chk({tag, "_out"}, cfg_out, exp_out());
    chk({tag, "_valid"}, cfg_valid, m_valid);
    chk({tag, "_err"}, cfg_err, m_err);
  endtask

  task automatic do_reset();
    prog_reset_n = 1'b0;
    tick();
    model_reset();
    prog_reset_n = 1'b1;
  endtask

  task automatic op_shift(input logic b);
    ccff_en   = 1'b1;
    ccff_head = b;
    tick();
    model_shift(b);
    ccff_en = 1'b0;
  endtask

  task automatic shift_word(input logic [63:0] data, input int hi, input int n);
    for (int i = 0; i < n; i++) op_shift(data[hi-i]);
  endtask

  // Commit and/or readback request, optionally with a shift in the same cycle
  // and optional ignored requests while the command cycle is in progress.
  task automatic op_cmd(input bit commit, input bit rb, input bit sh, input logic b, input bit noise);
    cfg_commit   = commit;
    cfg_readback = rb;
    ccff_en      = sh;
    ccff_head    = b;
    tick();
    if (sh) model_shift(b);
    cfg_commit = 1'b0; cfg_readback = 1'b0; ccff_en = 1'b0;
    chk("cmd_busy", busy, 1'b1);
    chk("cmd_done_early", cfg_done, 1'b0);
    if (noise) begin
      cfg_commit = 1'b1; cfg_readback = 1'b1; ccff_en = !ccff_bypass; ccff_head = ~b;
    end
    tick();
    cfg_commit = 1'b0; cfg_readback = 1'b0; ccff_en = 1'b0;
    if (commit) begin
      if (m_cnt == NB) begin
        m_sh = m_sr; m_valid = 1'b1; m_cnt = 0;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_sr = m_sh; m_cnt = 0;
    end
    chk("cmd_done", cfg_done, 1'b1);
    chk("cmd_busy_end", busy, 1'b0);
    chk_state("cmd");
    tick();
    chk("cmd_done_fall", cfg_done, 1'b0);
  endtask

  initial begin
    logic [63:0] d_a5, d_y, d_dead, d_z, d_w, d_ones;
    logic [9:0]  bpat;
    d_a5   = 64'hA5A5_0F0F_1234_5678;
    d_y    = 64'h3C3C_96E1_0BAD_F00D;
    d_dead = 64'hDEAD_BEEF_0000_FFFF;
    d_z    = 64'h5A5A_C3C3_7E7E_1818;
    d_w    = 64'h0F1E_2D3C_4B5A_6978;
    d_ones = {64{1'b1}};
    bpat   = 10'b1101001110;

    vt[0] = '{63, 64, d_a5, d_a5, 1'b1, 1'b0};
    vt[1] = '{63, 63, d_y,  d_a5, 1'b1, 1'b1};
    vt[2] = '{0,  1,  d_y,  d_y,  1'b1, 1'b1};

    prog_reset_n = 1'b0; ccff_head = 1'b0; ccff_en = 1'b0; ccff_bypass = 1'b0;
    cfg_commit = 1'b0; cfg_readback = 1'b0; isol_n = 1'b1;
    model_reset();

    // Reset state.
    tick();
    do_reset();
    chk("rst_tail", ccff_tail, 1'b0);
    chk("rst_out", cfg_out, 64'h0);
    chk("rst_valid", cfg_valid, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    isol_n = 1'b0; #1;
    chk("rst_iso", cfg_out, d_ones);
    isol_n = 1'b1; #1;

    // Full commit, under-shift commit, completing commit.
    for (int i = 0; i < 3; i++) begin
      shift_word(vt[i].data, vt[i].hi, vt[i].n);
      op_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("tbl_out", cfg_out, vt[i].exp_out);
      chk("tbl_valid", cfg_valid, vt[i].exp_valid);
      chk("tbl_err", cfg_err, vt[i].exp_err);
    end

    // Readback replays the shadow on the tail, MSB first.
    do_reset();
    shift_word(d_dead, 63, 64);
    op_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rb_commit_out", cfg_out, d_dead);
    op_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 64; k++) begin
      chk("rb_tail", ccff_tail, d_dead[63-k]);
      chk("rb_out", cfg_out, d_dead);
      op_shift(1'b0);
    end

    // Bypass: one-flop pass-through while the scan register and count freeze.
    op_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ccff_bypass = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op_shift(bpat[9-i]);
      chk("byp_tail", ccff_tail, bpat[9-i]);
    end
    ccff_bypass = 1'b0; #1;
    chk("byp_sr_frozen", ccff_tail, d_dead[63]);
    shift_word(d_z, 63, 63);
    op_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("byp_cnt_frozen", cfg_out, d_dead);
    chk("byp_err", cfg_err, 1'b1);
    shift_word(d_z, 0, 1);
    op_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("byp_commit", cfg_out, d_z);

    // Commit and readback together: commit wins, scan register not reloaded.
    shift_word(d_w, 63, 10);
    op_cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("both_out", cfg_out, d_z);
    shift_word(d_w, 53, 53);
    op_cmd(1'b1, 1'b0, 1'b1, d_w[0], 1'b0);
    chk("shift_commit_out", cfg_out, d_w);

    // Isolation is combinational in both directions.
    isol_n = 1'b0; #1;
    chk("iso_on", cfg_out, d_ones);
    isol_n = 1'b1; #1;
    chk("iso_off", cfg_out, d_w);

    // Reset during the COMMIT cycle aborts the commit.
    do_reset();
    shift_word(d_z, 63, 64);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("abort_busy", busy, 1'b1);
    prog_reset_n = 1'b0;
    tick();
    model_reset();
    prog_reset_n = 1'b1;
    chk("abort_out", cfg_out, 64'h0);
    chk("abort_done", cfg_done, 1'b0);
    chk("abort_busy_end", busy, 1'b0);
    chk("abort_valid", cfg_valid, 1'b0);
    tick();
    chk("abort_done_late", cfg_done, 1'b0);
    chk_state("abort");

    // Randomized operations against the model.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        ccff_bypass = ($urandom_range(0, 7) == 0);
        op_shift(1'($urandom_range(0, 1)));
      end else if (r == 5) begin
        int n;
        ccff_bypass = 1'b0;
        n = $urandom_range(60, 70);
        for (int j = 0; j < n; j++) op_shift(1'($urandom_range(0, 1)));
        op_cmd(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r == 6) begin
        op_cmd(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r == 7) begin
        op_cmd(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r == 8) begin
        op_cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        isol_n = ($urandom_range(0, 3) != 0);
        tick();
      end
      chk_state("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
